screen_refresh_ctrl: RTL and testbench
======================================

# screen_refresh_ctrl

Sequences the register renderer and owns the shared ASCII character-buffer write port. It periodically resets and restarts the renderer, and stalls the CPU while the renderer borrows the register-file read port. It arbitrates the buffer write port between the renderer and a console text writer, and the renderer has priority. Sits between the core, the renderer, the console writer and the character buffer.

## Interface
- REFRESH_CYCLES, 1666666: clk cycles between timer-triggered refreshes (≥2).
- TIMEOUT_CYCLES, 16384: max cycles in RENDER before abort (watchdog build only).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = periodic refresh timer runs.
- force_refresh  in  1  one-cycle pulse requests a refresh.
- rr_rst_n  out  1  active-low reset to renderer.
- rr_start  out  1  renderer start pulse.
- rr_done  in  1  renderer finished.
- rr_we / rr_data / rr_addr  in  1/32/13  renderer write request.
- con_req  in  1  console wants a write this cycle.
- con_data / con_addr  in  32/13  console write payload.
- con_gnt  out  1  console write accepted this cycle (combinational).
- buf_we / buf_data / buf_addr  out  1/32/13  character-buffer write port (registered).
- cpu_stall  out  1  core must hold; register file belongs to renderer.
- busy  out  1  state ≠ IDLE.
- err  out  1  sticky render-timeout flag.

## Operation
- States:
  - IDLE → CLEAR when pending=1.
  - CLEAR (rr_rst_n=0, 1 cycle) → KICK.
  - KICK (rr_start=1, 1 cycle) → RENDER.
  - RENDER → IDLE on rr_done=1.
- pending:
  - Set by force_refresh, or by timer wrap when enable=1.
  - Cleared on entry to CLEAR.
  - A set in the same cycle as the clear wins, so no request is lost.
- Timer:
  - 21-bit counter, counts 0..REFRESH_CYCLES-1 while enable=1, then wraps.
  - Wrap sets pending.
  - Holds its value while enable=0.
- Timer wrap and force_refresh in the same cycle produce one refresh.
- force_refresh during CLEAR/KICK/RENDER leaves pending set, so exactly one further refresh follows.
- rr_rst_n is 1 in all states except CLEAR and reset.
- cpu_stall = 1 in CLEAR, KICK, RENDER.
- Write-port arbitration:
  - con_gnt = con_req & (state==IDLE) & !pending.
  - In RENDER, rr_* drive the port.
  - Otherwise, con_* drive the port when con_gnt=1.
  - In all other cases buf_we=0.
- Console is not granted in CLEAR/KICK/RENDER; its request waits (no FIFO). The console holds con_req and payload until it sees con_gnt.

## Timing
- Reset values:
  - State IDLE, pending=1 (first frame drawn after reset).
  - Timer 0, err=0.
  - Outputs: rr_rst_n=0 (while rst high), rr_start=0, buf_we=0, buf_data=0, buf_addr=0, cpu_stall=0, busy=0, con_gnt=0.
- Refresh latency: pending set in cycle t while IDLE gives CLEAR at t+1, KICK at t+2, RENDER from t+3.
- Write-port latency: buf_* equal the selected request one cycle later, for both sources.
- Return to IDLE: rr_done sampled 1 in RENDER gives IDLE next cycle. cpu_stall drops in that same cycle.
- rst asserted mid-RENDER:
  - Immediate return to reset values; any in-flight buffer write is dropped.
  - Renderer is held in reset through rr_rst_n.
  - pending=1 after release.
- rr_we outside RENDER is ignored.

## Configuration
- SCREEN_REFRESH_WDT_EN defined:
  - A cycle counter runs in RENDER.
  - Reaching TIMEOUT_CYCLES forces IDLE, sets err (cleared only by rst) and releases cpu_stall.
  - rr_rst_n pulses low at the next CLEAR as usual.
- Not defined: no watchdog, err tied 0, RENDER waits for rr_done indefinitely.

## Test plan
- Reset release, REFRESH_CYCLES=100, enable=0 → CLEAR at cycle 1, rr_start pulse at cycle 2, cpu_stall=1 from cycle 1 until the cycle after rr_done; no second refresh in 1000 cycles.
- enable=1, REFRESH_CYCLES=100, renderer model finishing in 20 cycles → rr_start pulses exactly 100 cycles apart.
- con_req held with addr 0x0010 / data 0x41FFFFFF during RENDER → con_gnt=0 until IDLE; con_gnt=1 in the IDLE cycle; buf_we=1, buf_addr=0x0010, buf_data=0x41FFFFFF one cycle later.
- force_refresh and timer wrap in the same cycle, plus a second force_refresh during RENDER → exactly two rr_start pulses total.
- rst pulsed mid-RENDER → all outputs at reset values within the same cycle; a fresh CLEAR/KICK sequence after release.
- With SCREEN_REFRESH_WDT_EN, TIMEOUT_CYCLES=50, rr_done never asserted → IDLE and err=1 after 50 RENDER cycles; next refresh restarts normally and err stays 1.

Source files
------------

// File: rtl/screen_refresh_ctrl.sv
// screen_refresh_ctrl: sequences the register renderer (clear, kick, render)
// and arbitrates the character-buffer write port between the renderer and the
// console writer. The renderer always has priority.
// Optional render watchdog: define SCREEN_REFRESH_WDT_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a pending refresh; console may write
// CLEAR  | renderer held in reset for one cycle, CPU stalled
// KICK   | one-cycle start pulse to renderer, CPU stalled
// RENDER | renderer owns register file and buffer port until rr_done
module screen_refresh_ctrl #(
   parameter int REFRESH_CYCLES = 1666666,
   parameter int TIMEOUT_CYCLES = 16384
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        force_refresh,
   output logic        rr_rst_n,
   output logic        rr_start,
   input  logic        rr_done,
   input  logic        rr_we,
   input  logic [31:0] rr_data,
   input  logic [12:0] rr_addr,
   input  logic        con_req,
   input  logic [31:0] con_data,
   input  logic [12:0] con_addr,
   output logic        con_gnt,
   output logic        buf_we,
   output logic [31:0] buf_data,
   output logic [12:0] buf_addr,
   output logic        cpu_stall,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_KICK, S_RENDER} state_t;

   localparam logic [20:0] TIMER_LAST = 21'(REFRESH_CYCLES - 1);

   state_t      state_q, state_d;
   logic        pending_q, pending_d;
   logic [20:0] timer_q, timer_d;
   logic        timer_wrap;
   logic        buf_we_q, buf_we_d;
   logic [31:0] buf_data_q, buf_data_d;
   logic [12:0] buf_addr_q, buf_addr_d;
   logic        wdt_expire;

`ifdef SCREEN_REFRESH_WDT_EN
   localparam int WDT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(TIMEOUT_CYCLES - 1);

   logic [WDT_W-1:0] wdt_q, wdt_d;
   logic             err_q, err_d;

   // Watchdog counts RENDER cycles; restarts from zero on every entry.
   always_comb begin
      wdt_d = '0;
      if (state_q == S_RENDER) wdt_d = wdt_q + 1'b1;
   end

   assign wdt_expire = (state_q == S_RENDER) && (wdt_q == WDT_LAST);

   // A timeout coinciding with rr_done is a normal finish, not an error.
   always_comb begin
      err_d = err_q | (wdt_expire & ~rr_done);
   end

   // Watchdog counter and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdt_q <= '0;
         err_q <= 1'b0;
      end else begin
         wdt_q <= wdt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign wdt_expire = 1'b0;
   assign err        = 1'b0;
`endif

   // Free-running refresh timer; freezes while disabled.
   always_comb begin
      timer_d    = timer_q;
      timer_wrap = 1'b0;
      if (enable) begin
         if (timer_q == TIMER_LAST) begin
            timer_d    = '0;
            timer_wrap = 1'b1;
         end else begin
            timer_d = timer_q + 21'd1;
         end
      end
   end

   // A new request always wins over the clear taken on IDLE->CLEAR.
   always_comb begin
      pending_d = force_refresh | timer_wrap | (pending_q & (state_q != S_IDLE));
   end

   // Next-state logic for the refresh sequence.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (pending_q) state_d = S_CLEAR;
         S_CLEAR:  state_d = S_KICK;
         S_KICK:   state_d = S_RENDER;
         S_RENDER: if (rr_done || wdt_expire) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   assign con_gnt   = con_req & (state_q == S_IDLE) & ~pending_q;
   assign rr_rst_n  = ~rst & (state_q != S_CLEAR);
   assign rr_start  = (state_q == S_KICK);
   assign cpu_stall = (state_q != S_IDLE);
   assign busy      = (state_q != S_IDLE);

   // Buffer port mux: renderer in RENDER, otherwise a granted console write.
   always_comb begin
      buf_we_d   = 1'b0;
      buf_data_d = buf_data_q;
      buf_addr_d = buf_addr_q;
      if (state_q == S_RENDER) begin
         if (rr_we) begin
            buf_we_d   = 1'b1;
            buf_data_d = rr_data;
            buf_addr_d = rr_addr;
         end
      end else if (con_gnt) begin
         buf_we_d   = 1'b1;
         buf_data_d = con_data;
         buf_addr_d = con_addr;
      end
   end

   // State, request, timer and buffer-port registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pending_q  <= 1'b1;
         timer_q    <= '0;
         buf_we_q   <= 1'b0;
         buf_data_q <= '0;
         buf_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         timer_q    <= timer_d;
         buf_we_q   <= buf_we_d;
         buf_data_q <= buf_data_d;
         buf_addr_q <= buf_addr_d;
      end
   end

   assign buf_we   = buf_we_q;
   assign buf_data = buf_data_q;
   assign buf_addr = buf_addr_q;

endmodule

// File: tb/tb_screen_refresh_ctrl.sv
// Directed bench for screen_refresh_ctrl (REFRESH_CYCLES=100, TIMEOUT_CYCLES=50).
// Watchdog checks are built only when SCREEN_REFRESH_WDT_EN is defined.
module tb_screen_refresh_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        force_refresh;
   logic        rr_rst_n;
   logic        rr_start;
   logic        rr_done;
   logic        rr_we;
   logic [31:0] rr_data;
   logic [12:0] rr_addr;
   logic        con_req;
   logic [31:0] con_data;
   logic [12:0] con_addr;
   logic        con_gnt;
   logic        buf_we;
   logic [31:0] buf_data;
   logic [12:0] buf_addr;
   logic        cpu_stall;
   logic        busy;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;
   int rdly_cnt = 0;
   int start_log[$];

   screen_refresh_ctrl #(
      .REFRESH_CYCLES(100),
      .TIMEOUT_CYCLES(50)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .force_refresh(force_refresh),
      .rr_rst_n(rr_rst_n), .rr_start(rr_start), .rr_done(rr_done),
      .rr_we(rr_we), .rr_data(rr_data), .rr_addr(rr_addr),
      .con_req(con_req), .con_data(con_data), .con_addr(con_addr),
      .con_gnt(con_gnt), .buf_we(buf_we), .buf_data(buf_data),
      .buf_addr(buf_addr), .cpu_stall(cpu_stall), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run n cycles with a renderer model that raises rr_done for one cycle
   // dly cycles after it sees rr_start; logs the run-relative start cycles.
   task automatic run(input int n, input int dly);
      for (int i = 0; i < n; i++) begin
         tick();
         rr_done = 1'b0;
         if (rr_start) begin
            start_log.push_back(i + 1);
            rdly_cnt = dly;
         end else if (rdly_cnt > 0) begin
            rdly_cnt--;
            if (rdly_cnt == 0) rr_done = 1'b1;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rr_rst_n"},  rr_rst_n,  1'b0);
      check({tag, "_rr_start"},  rr_start,  1'b0);
      check({tag, "_buf_we"},    buf_we,    1'b0);
      check({tag, "_buf_data"},  buf_data,  32'h0);
      check({tag, "_buf_addr"},  buf_addr,  32'h0);
      check({tag, "_cpu_stall"}, cpu_stall, 1'b0);
      check({tag, "_busy"},      busy,      1'b0);
      check({tag, "_con_gnt"},   con_gnt,   1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; enable = 1'b0; force_refresh = 1'b0; rr_done = 1'b0;
      rr_we = 1'b0; rr_data = '0; rr_addr = '0;
      con_req = 1'b1; con_data = 32'h41FFFFFF; con_addr = 13'h0010;
      repeat (3) @(posedge clk);
      #1;
      // ---- reset values (console request present but never granted) ----
      check_reset_outputs("rst");
      check("rst_err", err, 1'b0);
      con_req = 1'b0;
      rst = 1'b0;
      #1;
      check("c0_rr_rst_n", rr_rst_n, 1'b1);
      check("c0_busy", busy, 1'b0);
      tick();
      check("c1_rr_rst_n", rr_rst_n, 1'b0);
      check("c1_cpu_stall", cpu_stall, 1'b1);
      check("c1_rr_start", rr_start, 1'b0);
      tick();
      check("c2_rr_start", rr_start, 1'b1);
      check("c2_rr_rst_n", rr_rst_n, 1'b1);
      tick();
      check("c3_rr_start", rr_start, 1'b0);
      check("c3_cpu_stall", cpu_stall, 1'b1);
      // ---- renderer write plus a blocked console request in RENDER ----
      con_req = 1'b1; con_addr = 13'h0010; con_data = 32'h41FFFFFF;
      rr_we = 1'b1; rr_addr = 13'h0123; rr_data = 32'hDEADBEEF;
      #1;
      check("render_con_gnt", con_gnt, 1'b0);
      tick();
      check("rr_wr_we", buf_we, 1'b1);
      check("rr_wr_addr", buf_addr, 32'h0123);
      check("rr_wr_data", buf_data, 32'hDEADBEEF);
      check("render_con_gnt2", con_gnt, 1'b0);
      rr_we = 1'b0;
      tick();
      check("render_idle_we", buf_we, 1'b0);
      rr_done = 1'b1;
      tick();
      rr_done = 1'b0;
      check("done_busy", busy, 1'b0);
      check("done_cpu_stall", cpu_stall, 1'b0);
      check("idle_con_gnt", con_gnt, 1'b1);
      tick();
      con_req = 1'b0;
      check("con_wr_we", buf_we, 1'b1);
      check("con_wr_addr", buf_addr, 32'h0010);
      check("con_wr_data", buf_data, 32'h41FFFFFF);
      // ---- renderer write outside RENDER is ignored ----
      rr_we = 1'b1; rr_addr = 13'h0777; rr_data = 32'h12345678;
      tick();
      rr_we = 1'b0;
      check("idle_rr_we_ignored", buf_we, 1'b0);
      // ---- no further refresh with the timer disabled ----
      start_log.delete();
      run(1000, 20);
      check("no_refresh_starts", start_log.size(), 0);
      // ---- periodic refresh, timer starts at 0 ----
      start_log.delete();
      enable = 1'b1;
      run(350, 20);
      check("periodic_starts", start_log.size(), 3);
      if (start_log.size() >= 3) begin
         check("periodic_first", start_log[0], 102);
         check("periodic_gap1", start_log[1] - start_log[0], 100);
         check("periodic_gap2", start_log[2] - start_log[1], 100);
      end
      // ---- timer at 50: force on the wrap edge, then again in RENDER ----
      start_log.delete();
      run(49, 20);
      force_refresh = 1'b1;
      run(1, 20);
      force_refresh = 1'b0;
      run(5, 20);
      check("mid_render_busy", busy, 1'b1);
      force_refresh = 1'b1;
      run(1, 20);
      force_refresh = 1'b0;
      enable = 1'b0;
      run(80, 20);
      check("coincident_starts", start_log.size(), 2);
      // ---- reset asserted mid-RENDER drops the in-flight write ----
      force_refresh = 1'b1;
      tick();
      force_refresh = 1'b0;
      tick();
      tick();
      tick();
      check("pre_rst_busy", busy, 1'b1);
      rr_we = 1'b1; rr_addr = 13'h1ABC; rr_data = 32'hCAFE0001;
      tick();
      check("pre_rst_buf_we", buf_we, 1'b1);
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      rr_we = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_clear", rr_rst_n, 1'b0);
      check("post_rst_stall", cpu_stall, 1'b1);
      tick();
      check("post_rst_kick", rr_start, 1'b1);
      tick();
      rr_done = 1'b1;
      tick();
      rr_done = 1'b0;
      check("post_rst_idle", busy, 1'b0);
`ifdef SCREEN_REFRESH_WDT_EN
      // ---- watchdog: renderer never finishes ----
      begin
         int n_render;
         n_render = 0;
         force_refresh = 1'b1;
         tick();
         force_refresh = 1'b0;
         tick();
         tick();
         tick();
         while (busy && n_render < 200) begin
            n_render++;
            tick();
         end
         check("wdt_render_cycles", n_render, 50);
         check("wdt_err", err, 1'b1);
         check("wdt_stall_released", cpu_stall, 1'b0);
         force_refresh = 1'b1;
         tick();
         force_refresh = 1'b0;
         tick();
         check("wdt_next_clear", rr_rst_n, 1'b0);
         tick();
         check("wdt_next_kick", rr_start, 1'b1);
         tick();
         rr_done = 1'b1;
         tick();
         rr_done = 1'b0;
         check("wdt_next_idle", busy, 1'b0);
         check("wdt_err_sticky", err, 1'b1);
      end
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
